// File: rtl/mapped_bus_fabric_if.sv
// Core memory bus seen by mapped_bus_fabric: request side from the master,
// registered read data and handshake flags back from the fabric.
interface mapped_bus_fabric_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] i_memAddr;
  logic [15:0]       i_memDataIn;
  logic              i_memWrEn;
  logic              i_memRdEn;
  logic [15:0]       o_memDataOut;
  logic              o_memReady;
  logic              o_memBusy;

  modport master (
    output i_memAddr, i_memDataIn, i_memWrEn, i_memRdEn,
    input  o_memDataOut, o_memReady, o_memBusy
  );

  modport slave (
    input  i_memAddr, i_memDataIn, i_memWrEn, i_memRdEn,
    output o_memDataOut, o_memReady, o_memBusy
  );
endinterface

// File: rtl/mapped_bus_fabric.sv
// Memory-mapped fabric: decodes the core bus onto NUM_SLOTS four-register slots
// with ready/wait handshake, timeout watchdog and a W1C error window.
module mapped_bus_fabric #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  mapped_bus_fabric_if.slave        bus,
  output logic [NUM_SLOTS-1:0]      o_slotSel,
  output logic [NUM_SLOTS-1:0]      o_slotWrEn,
  output logic [1:0]                o_slotAddr,
  output logic [15:0]               o_slotDataIn,
  input  logic [16*NUM_SLOTS-1:0]   i_slotDataOut,
  input  logic [NUM_SLOTS-1:0]      i_slotReady,
  output logic                      o_intErr
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_slotDataIn;
  logic                r_write;
  logic [3:0]          r_slotIdx;
  logic [7:0]          r_waitCnt;
  logic [15:0]         r_memDataOut;
  logic [1:0]          r_errStat;
  logic [ADDR_W-1:0]   r_errAddr;

  logic                w_req;
  logic                w_below;
  logic [ADDR_W-1:0]   w_off;
  logic [ADDR_W-3:0]   w_blk;
  logic                w_slotHit;
  logic                w_winHit;
  logic [15:0]         w_winRd;
  logic                w_slotRdy;
  logic [15:0]         w_slotRd;
  logic [NUM_SLOTS-1:0] w_slotOneHot;
  logic [8:0]          w_cntP1;
  logic                w_latch;
  logic                w_cntClr;
  logic                w_cntInc;
  logic                w_doneLoad;
  logic [15:0]         w_doneData;
  logic [1:0]          w_errSet;
  logic [1:0]          w_errClr;
  logic [ADDR_W-1:0]   w_errAddrVal;

  // Address decode relative to BASE_ADDR; addresses below the base never hit.
  assign w_req     = bus.i_memWrEn | bus.i_memRdEn;
  assign w_below   = bus.i_memAddr < ADDR_W'(BASE_ADDR);
  assign w_off     = bus.i_memAddr - ADDR_W'(BASE_ADDR);
  assign w_blk     = w_off[ADDR_W-1:2];
  assign w_slotHit = !w_below && (w_blk <  (ADDR_W-2)'(NUM_SLOTS));
  assign w_winHit  = !w_below && (w_blk == (ADDR_W-2)'(NUM_SLOTS));
  assign w_cntP1   = {1'b0, r_waitCnt} + 9'd1;

  always_comb begin
    w_winRd = 16'h0000;
    case (w_off[1:0])
      2'd0:    w_winRd = {14'h0000, r_errStat};
      2'd1:    w_winRd = 16'(r_errAddr);
      default: w_winRd = 16'h0000;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_slotRdy    = 1'b0;
    w_slotRd     = 16'h0000;
    w_slotOneHot = '0;
    w_stateNext  = r_state;
    w_latch      = 1'b0;
    w_cntClr     = 1'b0;
    w_cntInc     = 1'b0;
    w_doneLoad   = 1'b0;
    w_doneData   = 16'h0000;
    w_errSet     = 2'b00;
    w_errClr     = 2'b00;
    w_errAddrVal = r_addr;
    o_slotSel    = '0;
    o_slotWrEn   = '0;
    bus.o_memReady = 1'b0;
    bus.o_memBusy  = (r_state != S_IDLE);

    // Only the latched slot's ready and data are ever looked at.
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (r_slotIdx == 4'(k)) begin
        w_slotRdy       = i_slotReady[k];
        w_slotRd        = i_slotDataOut[16*k +: 16];
        w_slotOneHot[k] = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_latch = 1'b1;
          if (w_slotHit) begin
            w_stateNext = S_ACCESS;
            w_cntClr    = 1'b1;
          end else begin
            w_stateNext = S_DONE;
            w_doneLoad  = 1'b1;
            if (w_winHit) begin
              if (bus.i_memWrEn) begin
                if (w_off[1:0] == 2'd0) w_errClr = bus.i_memDataIn[1:0];
              end else begin
                w_doneData = w_winRd;
              end
            end else begin
              w_errSet     = 2'b01;
              w_errAddrVal = bus.i_memAddr;
            end
          end
        end
      end
      S_ACCESS: begin
        o_slotSel  = w_slotOneHot;
        o_slotWrEn = r_write ? w_slotOneHot : '0;
        if (w_slotRdy) begin
          w_stateNext = S_DONE;
          w_doneLoad  = 1'b1;
          w_doneData  = r_write ? 16'h0000 : w_slotRd;
        end else if (w_cntP1 == 9'(TIMEOUT)) begin
          w_stateNext = S_DONE;
          w_doneLoad  = 1'b1;
          w_errSet    = 2'b10;
        end else begin
          w_cntInc = 1'b1;
        end
      end
      S_DONE: begin
        bus.o_memReady = 1'b1;
        w_stateNext    = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Error set beats a simultaneous W1C; the address is kept only for the first error.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_addr       <= '0;
      r_slotDataIn <= 16'h0000;
      r_write      <= 1'b0;
      r_slotIdx    <= 4'd0;
      r_waitCnt    <= 8'd0;
      r_memDataOut <= 16'h0000;
      r_errStat    <= 2'b00;
      r_errAddr    <= '0;
    end else begin
      if (w_latch) begin
        r_addr       <= bus.i_memAddr;
        r_slotDataIn <= bus.i_memDataIn;
        r_write      <= bus.i_memWrEn;
        r_slotIdx    <= w_blk[3:0];
      end
      if (w_cntClr)      r_waitCnt <= 8'd0;
      else if (w_cntInc) r_waitCnt <= r_waitCnt + 8'd1;
      if (w_doneLoad)    r_memDataOut <= w_doneData;
      r_errStat <= (r_errStat & ~w_errClr) | w_errSet;
      if ((w_errSet != 2'b00) && (r_errStat == 2'b00)) r_errAddr <= w_errAddrVal;
    end
  end

  assign bus.o_memDataOut = r_memDataOut;
  assign o_slotAddr       = r_addr[1:0];
  assign o_slotDataIn     = r_slotDataIn;
  assign o_intErr         = |r_errStat;

endmodule

// File: tb/tb_mapped_bus_fabric.sv
// Directed bench for mapped_bus_fabric: table of single transactions against a
// behavioural slot model, plus hand-written busy-intrusion and reset sequences.
module tb_mapped_bus_fabric;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned NS     = 4;
  localparam logic [13:0] B      = 14'h0100;

  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;
  logic [NS-1:0]    o_slotSel, o_slotWrEn;
  logic [1:0]       o_slotAddr;
  logic [15:0]      o_slotDataIn;
  logic [16*NS-1:0] slotDataOut = '0;
  logic [NS-1:0]    slotReady = '0;
  logic             o_intErr;

  mapped_bus_fabric_if #(.ADDR_W(ADDR_W)) bus();

  mapped_bus_fabric #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h100), .NUM_SLOTS(NS), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .bus(bus),
    .o_slotSel(o_slotSel), .o_slotWrEn(o_slotWrEn), .o_slotAddr(o_slotAddr),
    .o_slotDataIn(o_slotDataIn), .i_slotDataOut(slotDataOut),
    .i_slotReady(slotReady), .o_intErr(o_intErr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [13:0] addr;
    logic [15:0] wdata;
    int          delay;
    int          iCyc;
    logic [13:0] iAddr;
    logic [15:0] iData;
    logic [15:0] expData;
    int          expLat;
    logic [1:0]  expStat;
    logic [3:0]  expWrEn;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;
  int slotDelay = 0;
  int slotWait[NS];
  logic [15:0] slotMem[NS][4];

  // Slot model: ready after slotDelay selected cycles (negative = never).
  always @(negedge i_clk) begin
    for (int k = 0; k < NS; k++) begin
      if (o_slotSel[k]) begin
        slotReady[k] = (slotDelay >= 0) && (slotWait[k] >= slotDelay);
        slotWait[k]  = slotWait[k] + 1;
        slotDataOut[16*k +: 16] = slotMem[k][o_slotAddr];
      end else begin
        slotReady[k] = 1'b0;
        slotWait[k]  = 0;
        slotDataOut[16*k +: 16] = 16'hDEA0 | 16'(k);
      end
    end
  end

  always @(posedge i_clk) begin
    for (int k = 0; k < NS; k++)
      if (o_slotWrEn[k] && slotReady[k]) slotMem[k][o_slotAddr] = o_slotDataIn;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void addVec(input bit wr, input bit rd, input logic [13:0] addr,
                                 input logic [15:0] wdata, input int delay, input int iCyc,
                                 input logic [13:0] iAddr, input logic [15:0] iData,
                                 input logic [15:0] expData, input int expLat,
                                 input logic [1:0] expStat, input logic [3:0] expWrEn);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.delay = delay;
    v.iCyc = iCyc; v.iAddr = iAddr; v.iData = iData; v.expData = expData;
    v.expLat = expLat; v.expStat = expStat; v.expWrEn = expWrEn;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input int idx, input vec_t v);
    int lat, strobes;
    bit done, busyOk, addrOk;
    logic [NS-1:0] wrSeen;
    string tag;
    tag = $sformatf("v%0d", idx);
    slotDelay = v.delay;
    @(negedge i_clk);
    bus.i_memAddr = v.addr; bus.i_memDataIn = v.wdata;
    bus.i_memWrEn = v.wr;   bus.i_memRdEn = v.rd;
    @(negedge i_clk);
    bus.i_memWrEn = 1'b0; bus.i_memRdEn = 1'b0;
    lat = 1; strobes = 0; done = 0; busyOk = 1; addrOk = 1; wrSeen = '0;
    while (!done && lat <= 40) begin
      if (bus.o_memReady) done = 1;
      else begin
        if (!bus.o_memBusy) busyOk = 0;
        if (o_slotSel != '0) begin
          strobes++;
          if (o_slotAddr !== v.addr[1:0]) addrOk = 0;
        end
        wrSeen |= o_slotWrEn;
        if (v.iCyc == lat) begin
          bus.i_memAddr = v.iAddr; bus.i_memDataIn = v.iData; bus.i_memWrEn = 1'b1;
        end
        @(negedge i_clk);
        bus.i_memWrEn = 1'b0; bus.i_memRdEn = 1'b0;
        lat++;
      end
    end
    checkOutput({tag, " ready seen"}, 32'(done), 32'd1);
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.expLat));
    checkOutput({tag, " data"}, 32'(bus.o_memDataOut), 32'(v.expData));
    checkOutput({tag, " busy held"}, 32'(busyOk), 32'd1);
    checkOutput({tag, " strobe cycles"}, 32'(strobes), 32'(v.expLat > 1 ? v.expLat - 1 : 0));
    checkOutput({tag, " slot wren"}, 32'(wrSeen), 32'(v.expWrEn));
    checkOutput({tag, " slot addr"}, 32'(addrOk), 32'd1);
    @(negedge i_clk);
    checkOutput({tag, " ready one cycle"}, {30'd0, bus.o_memReady, bus.o_memBusy}, 32'd0);
    checkOutput({tag, " intErr"}, 32'(o_intErr), 32'(|v.expStat));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int seen;
    for (int k = 0; k < NS; k++) begin
      slotWait[k] = 0;
      for (int r = 0; r < 4; r++) slotMem[k][r] = 16'h0000;
    end
    bus.i_memAddr = '0; bus.i_memDataIn = '0; bus.i_memWrEn = 1'b0; bus.i_memRdEn = 1'b0;

    //     wr rd addr     wdata    dly iC iAddr    iData    expData  lat stat wrEn
    addVec(1, 0, B+9,  16'hBEEF,  0, 0, B,     16'h0,    16'h0000, 2, 2'b00, 4'b0100);
    addVec(0, 1, B+9,  16'h0,     0, 0, B,     16'h0,    16'hBEEF, 2, 2'b00, 4'b0000);
    addVec(1, 0, B+0,  16'h1234,  3, 0, B,     16'h0,    16'h0000, 5, 2'b00, 4'b0001);
    addVec(0, 1, B+0,  16'h0,     3, 2, B+9,   16'h0BAD, 16'h1234, 5, 2'b00, 4'b0000);
    addVec(1, 0, B+15, 16'hA5A5,  0, 0, B,     16'h0,    16'h0000, 2, 2'b00, 4'b1000);
    addVec(0, 1, B+15, 16'h0,     0, 0, B,     16'h0,    16'hA5A5, 2, 2'b00, 4'b0000);
    addVec(1, 1, B+14, 16'h5A5A,  0, 0, B,     16'h0,    16'h0000, 2, 2'b00, 4'b1000);
    addVec(0, 1, B+14, 16'h0,     0, 0, B,     16'h0,    16'h5A5A, 2, 2'b00, 4'b0000);
    addVec(0, 1, B+9,  16'h0,    14, 0, B,     16'h0,    16'hBEEF, 16, 2'b00, 4'b0000);
    addVec(0, 1, B+0,  16'h0,    14, 0, B,     16'h0,    16'h1234, 16, 2'b00, 4'b0000);
    addVec(0, 1, B+16, 16'h0,     0, 0, B,     16'h0,    16'h0000, 1, 2'b00, 4'b0000);
    addVec(0, 1, B+5,  16'h0,    -1, 0, B,     16'h0,    16'h0000, 16, 2'b10, 4'b0000);
    addVec(0, 1, B+16, 16'h0,     0, 0, B,     16'h0,    16'h0002, 1, 2'b10, 4'b0000);
    addVec(0, 1, B+17, 16'h0,     0, 0, B,     16'h0,    16'h0105, 1, 2'b10, 4'b0000);
    addVec(0, 1, B+18, 16'h0,     0, 0, B,     16'h0,    16'h0000, 1, 2'b10, 4'b0000);
    addVec(1, 0, B+16, 16'h0003,  0, 0, B,     16'h0,    16'h0000, 1, 2'b00, 4'b0000);
    addVec(0, 1, B+16, 16'h0,     0, 0, B,     16'h0,    16'h0000, 1, 2'b00, 4'b0000);
    addVec(0, 1, B+20, 16'h0,     0, 0, B,     16'h0,    16'h0000, 1, 2'b01, 4'b0000);
    addVec(0, 1, B+16, 16'h0,     0, 0, B,     16'h0,    16'h0001, 1, 2'b01, 4'b0000);
    addVec(1, 0, B+6,  16'h7777, -1, 0, B,     16'h0,    16'h0000, 16, 2'b11, 4'b0010);
    addVec(0, 1, B+16, 16'h0,     0, 0, B,     16'h0,    16'h0003, 1, 2'b11, 4'b0000);
    addVec(0, 1, B+17, 16'h0,     0, 0, B,     16'h0,    16'h0114, 1, 2'b11, 4'b0000);
    addVec(1, 0, B+17, 16'hFFFF,  0, 0, B,     16'h0,    16'h0000, 1, 2'b11, 4'b0000);
    addVec(0, 1, B+17, 16'h0,     0, 0, B,     16'h0,    16'h0114, 1, 2'b11, 4'b0000);
    addVec(1, 0, B+16, 16'h0002,  0, 0, B,     16'h0,    16'h0000, 1, 2'b01, 4'b0000);
    addVec(0, 1, B+16, 16'h0,     0, 0, B,     16'h0,    16'h0001, 1, 2'b01, 4'b0000);
    addVec(1, 0, 14'h00FF, 16'h1, 0, 0, B,     16'h0,    16'h0000, 1, 2'b01, 4'b0000);
    addVec(0, 1, B+17, 16'h0,     0, 0, B,     16'h0,    16'h0114, 1, 2'b01, 4'b0000);
    addVec(1, 0, B+16, 16'h0001,  0, 0, B,     16'h0,    16'h0000, 1, 2'b00, 4'b0000);
    addVec(1, 0, 14'h00FF, 16'h1, 0, 0, B,     16'h0,    16'h0000, 1, 2'b01, 4'b0000);
    addVec(0, 1, B+17, 16'h0,     0, 0, B,     16'h0,    16'h00FF, 1, 2'b01, 4'b0000);
    addVec(1, 0, B+16, 16'h0001,  0, 0, B,     16'h0,    16'h0000, 1, 2'b00, 4'b0000);
    // W1C of bit0 lands on the very cycle the timeout aborts; bit1 must survive.
    addVec(0, 1, B+4,  16'h0,    -1, 15, B+16, 16'h0001, 16'h0000, 16, 2'b10, 4'b0000);
    addVec(0, 1, B+16, 16'h0,     0, 0, B,     16'h0,    16'h0002, 1, 2'b10, 4'b0000);
    addVec(0, 1, B+17, 16'h0,     0, 0, B,     16'h0,    16'h0104, 1, 2'b10, 4'b0000);
    addVec(1, 0, B+16, 16'h0003,  0, 0, B,     16'h0,    16'h0000, 1, 2'b00, 4'b0000);
    addVec(0, 1, B+20, 16'h0,     0, 0, B,     16'h0,    16'h0000, 1, 2'b01, 4'b0000);

    repeat (3) @(negedge i_clk);
    checkOutput("reset dataOut", 32'(bus.o_memDataOut), 32'd0);
    checkOutput("reset ready/busy", {30'd0, bus.o_memReady, bus.o_memBusy}, 32'd0);
    checkOutput("reset slotSel/wrEn", {24'd0, o_slotSel, o_slotWrEn}, 32'd0);
    checkOutput("reset slotAddr/dataIn", {14'd0, o_slotAddr, o_slotDataIn}, 32'd0);
    checkOutput("reset intErr", 32'(o_intErr), 32'd0);
    i_rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

    // Reset in the middle of a stalled slot-3 access must abort without acknowledge.
    slotDelay = -1;
    @(negedge i_clk);
    bus.i_memAddr = B + 14'd12; bus.i_memRdEn = 1'b1;
    @(negedge i_clk);
    bus.i_memRdEn = 1'b0;
    repeat (2) @(negedge i_clk);
    checkOutput("pre-reset slotSel", 32'(o_slotSel), 32'h8);
    i_rstn = 1'b0;
    #1;
    checkOutput("reset slotSel drop", 32'(o_slotSel), 32'd0);
    checkOutput("reset busy drop", 32'(bus.o_memBusy), 32'd0);
    checkOutput("reset intErr drop", 32'(o_intErr), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (bus.o_memReady) seen++;
    end
    checkOutput("no ready after reset", 32'(seen), 32'd0);
    checkOutput("dataOut after reset", 32'(bus.o_memDataOut), 32'd0);
    v = vecs[5];
    applyStimulus(99, v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mapped_bus_fabric.md
# mapped_bus_fabric

Parametrised successor to the fixed memory-mapped register decoder. It connects the core memory bus to NUM_SLOTS peripheral slots of four 16-bit registers each, and adds three things the fixed decoder lacks: a per-slot ready/wait handshake, a timeout watchdog, and registered read data. Decode and timeout errors are captured in an internal error window and raised as an interrupt flag for the NVIC.

## Interface
- ADDR_W, 14, memory bus word-address width
- BASE_ADDR, 0, word address of slot 0; must be a multiple of 4
- NUM_SLOTS, 4, number of peripheral slots, legal range 1..15
- TIMEOUT, 15, maximum ACCESS cycles before abort, legal range 1..255
- i_clk  in  1  single clock; all state updates on the rising edge
- i_rstn  in  1  asynchronous, active-low reset
- i_memAddr  in  ADDR_W  request word address
- i_memDataIn  in  16  write data
- i_memWrEn  in  1  write request, one-cycle pulse
- i_memRdEn  in  1  read request, one-cycle pulse
- o_memDataOut  out  16  registered read data
- o_memReady  out  1  one-cycle completion pulse
- o_memBusy  out  1  high whenever state is not IDLE
- o_slotSel  out  NUM_SLOTS  one-hot slot select, held through ACCESS
- o_slotWrEn  out  NUM_SLOTS  one-hot write strobe, held through ACCESS
- o_slotAddr  out  2  register offset within the slot
- o_slotDataIn  out  16  latched write data
- i_slotDataOut  in  16*NUM_SLOTS  slot k read data on bits [16k+15:16k]
- i_slotReady  in  NUM_SLOTS  slot k completion acknowledge
- o_intErr  out  1  high when any error status bit is set

## Operation
- Address map:
  - Slot k occupies BASE_ADDR+4k .. BASE_ADDR+4k+3.
  - Internal error window occupies BASE_ADDR+4*NUM_SLOTS .. +3.
  - Every other address is a decode error.
- Internal window registers:
  - Word 0, ERR_STAT: bit0 = decode error, bit1 = timeout error, bits 15:2 read 0. Write-1-to-clear.
  - Word 1, ERR_ADDR: low ADDR_W bits hold the address of the first error since the last time ERR_STAT was fully clear. Read-only.
  - Words 2–3 read 0; writes to them are ignored.
- State machine: IDLE, ACCESS, DONE.
  - IDLE: a request (WrEn or RdEn) latches address, data and direction. If both WrEn and RdEn are high, the write takes precedence.
    - Slot hit -> ACCESS.
    - Internal-window hit -> performs the access this cycle -> DONE.
    - Decode error -> DONE with read data 0 and ERR_STAT bit0 set; writes are dropped.
  - ACCESS: o_slotSel[k] is high; o_slotWrEn[k] is high for writes.
    - If i_slotReady[k]: capture the slot's read data (or 0 for a write) -> DONE.
    - Else increment the 8-bit wait counter. When the counter equals TIMEOUT, abort: read data 0, set ERR_STAT bit1 -> DONE.
  - DONE: o_memReady=1 for this cycle only -> IDLE.
- Requests arriving outside IDLE are ignored; the master must observe o_memBusy.
- i_slotReady from unselected slots is ignored.
- ERR_ADDR is captured only when ERR_STAT is 0 at the time of the error.
- If an error sets a bit in the same cycle that a W1C write clears it, the set wins.
- o_intErr = |ERR_STAT, driven combinationally from registered state.

## Timing
- Reset values: state IDLE, o_memDataOut=0, o_memReady=0, o_memBusy=0, o_slotSel=0, o_slotWrEn=0, o_slotAddr=0, o_slotDataIn=0, ERR_STAT=0, ERR_ADDR=0, wait counter=0, o_intErr=0.
- Slot access, ready in the first ACCESS cycle: request at cycle 0, strobe at cycle 1, o_memReady at cycle 2. Each additional wait cycle adds one cycle of latency.
- Internal-window access or decode error: o_memReady at cycle 1.
- Timeout: strobes are high for exactly TIMEOUT cycles, and o_memReady follows in the next cycle.
- o_memDataOut is updated only on entry to DONE and holds its value until the next completion.
- Asserting i_rstn low mid-access drops all strobes, the busy flag and the ready pulse immediately. The aborted transaction is never acknowledged.
- The wait counter clears on every entry to ACCESS.

## Test plan
- Write and read back on slot 2, offset 1, with ready in the same cycle. Write 0xBEEF at BASE+9, then read it back. Required: o_slotWrEn=4'b0100 for one cycle, then o_memDataOut=0xBEEF with o_memReady at cycle 2.
- Wait states: slot 0 raises ready after 3 cycles. Required: o_memReady at cycle 5, o_memBusy high in cycles 1–4, and no second request accepted during busy.
- Timeout (TIMEOUT=15, slot 1 never ready). Required: strobe for 15 cycles, then o_memReady with data 0, ERR_STAT=0x0002, ERR_ADDR=the requested address, o_intErr=1.
- Decode error, then a second error:
  - Read BASE+4*NUM_SLOTS+4. Required: ready at cycle 1, data 0, ERR_STAT=0x0001.
  - Then a timeout. Required: ERR_STAT=0x0003, ERR_ADDR unchanged.
- W1C race: write 0x0001 to ERR_STAT in the same cycle a timeout fires. Required: ERR_STAT ends at 0x0002. A W1C of 0x0003 then drives o_intErr=0.
- Assert reset during ACCESS on slot 3. Required: o_slotSel=0 and o_memBusy=0 immediately, with no o_memReady pulse. A subsequent request completes normally.
